// File: rtl/score_tally.sv
// Round-based scorekeeper for four players: accumulates saturating per-player
// totals over ROUNDS accepted score vectors, then registers the leader mask.

module score_tally_lane #(
    parameter int CNT_W = 4
) (
    input  logic [CNT_W-1:0] tot,
    input  logic             inc,
    output logic [CNT_W-1:0] nxt
);
    // Each player saturates independently at all-ones.
    always_comb begin
        nxt = tot;
        if (inc && (tot != {CNT_W{1'b1}})) nxt = tot + CNT_W'(1);
    end
endmodule

module score_tally #(
    parameter int ROUNDS = 8,
    parameter int CNT_W  = 4,
    localparam int RC_W  = $clog2(ROUNDS + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               score_valid,
    input  logic [3:0]         score,
    output logic               ready,
    output logic [4*CNT_W-1:0] totals,
    output logic [RC_W-1:0]    round_cnt,
    output logic               busy,
    output logic               done,
    output logic [3:0]         winner
);
    localparam int NUM_P = 4;
    localparam logic [RC_W-1:0] LAST_RND = RC_W'(ROUNDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, CALC, DONE} state_t;

    state_t                        state_q, state_d;
    logic [NUM_P-1:0][CNT_W-1:0]   tot_q, tot_d, tot_nxt;
    logic [RC_W-1:0]               rc_q, rc_d;
    logic [3:0]                    win_q, win_d, win_mask;
    logic                          busy_q, busy_d, done_q, done_d;
    logic [CNT_W-1:0]              max_tot;
    logic                          accept;

    for (genvar i = 0; i < NUM_P; i++) begin : g_lane
        score_tally_lane #(.CNT_W(CNT_W)) u_lane (
            .tot (tot_q[i]),
            .inc (score[i]),
            .nxt (tot_nxt[i])
        );
    end

    always_comb begin
        max_tot = '0;
        for (int i = 0; i < NUM_P; i++)
            if (tot_q[i] > max_tot) max_tot = tot_q[i];
        win_mask = '0;
        // An all-zero game has no leader.
        for (int i = 0; i < NUM_P; i++)
            win_mask[i] = (max_tot != '0) && (tot_q[i] == max_tot);
    end

    assign accept = score_valid && (state_q == RUN);

    always_comb begin
        state_d = state_q;
        tot_d   = tot_q;
        rc_d    = rc_q;
        win_d   = win_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    tot_d   = '0;
                    rc_d    = '0;
                    win_d   = '0;
                end
            end
            RUN: begin
                if (accept) begin
                    tot_d = tot_nxt;
                    rc_d  = rc_q + RC_W'(1);
                    if (rc_q == LAST_RND) state_d = CALC;
                end
            end
            CALC: begin
                win_d   = win_mask;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RUN) || (state_d == CALC);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tot_q   <= '0;
            rc_q    <= '0;
            win_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tot_q   <= tot_d;
            rc_q    <= rc_d;
            win_q   <= win_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign ready     = (state_q == RUN);
    assign totals    = tot_q;
    assign round_cnt = rc_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign winner    = win_q;
endmodule

// File: tb/tb_score_tally.sv
// Directed bench for score_tally: default instance (ROUNDS=8, CNT_W=4) plus a
// saturating instance (ROUNDS=10, CNT_W=3).

module tb_score_tally;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance A: defaults
    logic        a_start, a_sv;
    logic [3:0]  a_score;
    logic        a_ready, a_busy, a_done;
    logic [15:0] a_totals;
    logic [3:0]  a_rc;
    logic [3:0]  a_win;

    // Instance B: ROUNDS=10, CNT_W=3
    logic        b_start, b_sv;
    logic [3:0]  b_score;
    logic        b_ready, b_busy, b_done;
    logic [11:0] b_totals;
    logic [3:0]  b_rc;
    logic [3:0]  b_win;

    int n_tests = 0;
    int n_fail  = 0;

    score_tally u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .score_valid(a_sv),
        .score(a_score), .ready(a_ready), .totals(a_totals),
        .round_cnt(a_rc), .busy(a_busy), .done(a_done), .winner(a_win)
    );

    score_tally #(.ROUNDS(10), .CNT_W(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .score_valid(b_sv),
        .score(b_score), .ready(b_ready), .totals(b_totals),
        .round_cnt(b_rc), .busy(b_busy), .done(b_done), .winner(b_win)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // All drives happen on the falling edge; checks read settled values there.
    task automatic start_a();
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
    endtask

    task automatic feed_a(input logic [3:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            a_sv = 1'b1; a_score = v;
            @(negedge clk);
        end
        a_sv = 1'b0; a_score = '0;
    endtask

    task automatic check_a_done(input string tag, input logic [15:0] tot, input logic [3:0] win);
        chk({tag, "_calc_busy"}, 32'(a_busy), 32'd1);
        chk({tag, "_calc_done"}, 32'(a_done), 32'd0);
        chk({tag, "_calc_rdy"},  32'(a_ready), 32'd0);
        @(negedge clk);
        chk({tag, "_done"},   32'(a_done), 32'd1);
        chk({tag, "_busy"},   32'(a_busy), 32'd0);
        chk({tag, "_totals"}, 32'(a_totals), 32'(tot));
        chk({tag, "_winner"}, 32'(a_win), 32'(win));
        chk({tag, "_rc"},     32'(a_rc), 32'd8);
    endtask

    logic [3:0] mix [8];

    initial begin
        mix = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b1000, 4'b0010, 4'b0100, 4'b0001};
        rst_n = 1'b0;
        a_start = 0; a_sv = 0; a_score = 0;
        b_start = 0; b_sv = 0; b_score = 0;
        repeat (3) @(negedge clk);
        chk("rst_totals", 32'(a_totals), 32'd0);
        chk("rst_rc",     32'(a_rc),     32'd0);
        chk("rst_winner", 32'(a_win),    32'd0);
        chk("rst_ready",  32'(a_ready),  32'd0);
        chk("rst_busy",   32'(a_busy),   32'd0);
        chk("rst_done",   32'(a_done),   32'd0);
        rst_n = 1'b1;

        // score_valid in IDLE is dropped
        feed_a(4'b1111, 2);
        chk("idle_drop_tot", 32'(a_totals), 32'd0);
        chk("idle_drop_rc",  32'(a_rc),     32'd0);

        // Game 1: player 0 scores every round
        start_a();
        chk("g1_ready", 32'(a_ready), 32'd1);
        chk("g1_busy",  32'(a_busy),  32'd1);
        feed_a(4'b0001, 7);
        chk("g1_rc7",   32'(a_rc),    32'd7);
        chk("g1_nodone", 32'(a_done), 32'd0);
        feed_a(4'b0001, 1);
        check_a_done("g1", 16'h0008, 4'b0001);

        // DONE holds under stray score_valid
        feed_a(4'b1111, 1);
        chk("done_hold_tot", 32'(a_totals), 32'h0008);
        chk("done_hold_win", 32'(a_win),    32'h1);

        // Restart from DONE clears everything next cycle
        start_a();
        chk("g2_clr_tot",  32'(a_totals), 32'd0);
        chk("g2_clr_rc",   32'(a_rc),     32'd0);
        chk("g2_clr_done", 32'(a_done),   32'd0);
        chk("g2_clr_win",  32'(a_win),    32'd0);
        chk("g2_ready",    32'(a_ready),  32'd1);
        feed_a(4'b1111, 8);
        check_a_done("g2", 16'h8888, 4'b1111);

        // All-zero game: no leader
        start_a();
        feed_a(4'b0000, 8);
        check_a_done("g3", 16'h0000, 4'b0000);

        // Mixed vectors with idle gaps: p0=3 p1=4 p2=2 p3=1
        start_a();
        for (int i = 0; i < 8; i++) begin
            feed_a(mix[i], 1);
            if (i == 3) begin
                @(negedge clk);
                chk("mix_gap_rc", 32'(a_rc), 32'd4);
            end
        end
        check_a_done("g4", 16'h1243, 4'b0010);

        // Instance B: player 2 saturates at 7 over 10 rounds
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            b_sv = 1'b1; b_score = 4'b0100;
            @(negedge clk);
        end
        b_sv = 1'b0; b_score = '0;
        chk("sat_calc_done", 32'(b_done), 32'd0);
        @(negedge clk);
        chk("sat_done",   32'(b_done),   32'd1);
        chk("sat_totals", 32'(b_totals), 32'h1C0);
        chk("sat_winner", 32'(b_win),    32'h4);
        chk("sat_rc",     32'(b_rc),     32'd10);

        // Mid-game: start ignored, idle cycles hold, async reset clears
        start_a();
        feed_a(4'b0101, 3);
        start_a();
        chk("mid_start_rc",  32'(a_rc),     32'd3);
        chk("mid_start_tot", 32'(a_totals), 32'h0303);
        repeat (5) @(negedge clk);
        chk("mid_idle_rc",   32'(a_rc),     32'd3);
        chk("mid_idle_tot",  32'(a_totals), 32'h0303);
        chk("mid_busy",      32'(a_busy),   32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_tot",   32'(a_totals), 32'd0);
        chk("arst_rc",    32'(a_rc),     32'd0);
        chk("arst_busy",  32'(a_busy),   32'd0);
        chk("arst_ready", 32'(a_ready),  32'd0);
        chk("arst_done",  32'(a_done),   32'd0);
        chk("arst_win",   32'(a_win),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(a_ready), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
